// File: rtl/sorted_array_reader_pkg.sv
// Shared state encoding and default sizing for the sorted-array read-out engine.
package sorted_array_reader_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/sorted_array_reader_fifo2.sv
// Two-entry synchronous FIFO buffering memory read data (word plus last flag).
module sorted_array_reader_fifo2 #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] slot0_q, slot1_q;
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr_q) slot1_q <= push_data_i;
                else          slot0_q <= push_data_i;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = rd_ptr_q ? slot1_q : slot0_q;
    assign count_o = count_q;

endmodule

// File: rtl/sorted_array_reader.sv
// Sweeps the sort memory through its synchronous read port, streams the words
// out over valid/ready and flags any descending neighbour pair.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; order_err holds its last value
//   S_READ  | issuing reads 0..DEPTH-1 under a 2-word credit limit
//   S_DRAIN | all reads issued; waiting for in-flight data and FIFO to empty
//   S_DONE  | one-cycle done pulse
module sorted_array_reader #(
    parameter int DATA_W = sorted_array_reader_pkg::DATA_W,
    parameter int ADDR_W = sorted_array_reader_pkg::ADDR_W,
    parameter int DEPTH  = sorted_array_reader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              order_err_o
);

    import sorted_array_reader_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_last_q;
    logic              first_q, first_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              order_err_q, order_err_d;

    logic              issue, pop, addr_at_last;
    logic [1:0]        fifo_count, credit;
    logic [DATA_W:0]   fifo_head;

    sorted_array_reader_fifo2 #(
        .WIDTH(DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i({inflight_last_q, mem_rdata_i}),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    assign out_valid_o  = (fifo_count != 2'd0);
    assign out_data_o   = fifo_head[DATA_W-1:0];
    assign out_last_o   = out_valid_o & fifo_head[DATA_W];
    assign pop          = out_valid_o & out_ready_i;
    assign addr_at_last = (addr_q == LAST_ADDR);
    // Credit counts the read already in flight so its data always has a slot.
    assign credit       = fifo_count + {1'b0, inflight_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        first_d     = first_q;
        prev_d      = prev_q;
        order_err_d = order_err_q;
        issue       = 1'b0;

        if (pop) begin
            if (!first_q && (prev_q > out_data_o)) begin
                order_err_d = 1'b1;
            end
            prev_d  = out_data_o;
            first_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_READ;
                    addr_d      = '0;
                    order_err_d = 1'b0;
                    first_d     = 1'b1;
                end
            end
            S_READ: begin
                issue = (credit < 2'd2) || pop;
                if (issue) begin
                    if (addr_at_last) state_d = S_DRAIN;
                    else              addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave as the last word departs so done lands the cycle after it.
                if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            first_q         <= 1'b0;
            prev_q          <= '0;
            order_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & addr_at_last;
            first_q         <= first_d;
            prev_q          <= prev_d;
            order_err_q     <= order_err_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign mem_rd_o    = issue;
    assign mem_addr_o  = addr_q;
    assign order_err_o = order_err_q;

endmodule

// File: tb/tb_sorted_array_reader.sv
// Directed bench for sorted_array_reader with a behavioural synchronous-read memory.
module tb_sorted_array_reader;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int N  = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i;
    logic          busy_o, done_o, mem_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_rdata_i;
    logic          out_valid_o, out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          out_last_o, order_err_o;

    always #5 clk = ~clk;

    sorted_array_reader #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .DEPTH (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .mem_rd_o   (mem_rd_o),
        .mem_addr_o (mem_addr_o),
        .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .order_err_o(order_err_o)
    );

    logic [DW-1:0] mem [N];
    logic [DW-1:0] got [$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  first_valid_cyc, pop1_cyc, err_cyc, done_cyc, done_cnt;
    int  got_last_cnt, last_pos, outst, max_outst;
    bit  ready_rand = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One clock: observe at the falling edge, then drive memory data and ready after the rising edge.
    task automatic step();
        logic          rd_fire;
        logic [AW-1:0] rd_a;
        @(negedge clk);
        if (outst > max_outst) max_outst = outst;
        if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid_o && out_ready_i) begin
            if (got.size() == 1) pop1_cyc = cyc;
            if (out_last_o) begin
                got_last_cnt++;
                last_pos = got.size();
            end
            got.push_back(out_data_o);
            outst--;
        end
        if (mem_rd_o) outst++;
        if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (order_err_o && err_cyc < 0) err_cyc = cyc;
        rd_fire = mem_rd_o;
        rd_a    = mem_addr_o;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_fire) mem_rdata_i = mem[rd_a];
        out_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic run_sweep(input bit rnd, input int poke_at, input int rst_at, output int k);
        bit poked = 1'b0;
        bit finished = 1'b0;
        got.delete();
        first_valid_cyc = -1; pop1_cyc = -1; err_cyc = -1; done_cyc = -1;
        done_cnt = 0; got_last_cnt = 0; last_pos = -1; outst = 0; max_outst = 0;
        ready_rand  = rnd;
        out_ready_i = 1'b1;
        start_i = 1'b1;
        k = cyc + 1;
        step();
        start_i = 1'b0;
        check_eq("err_clear_on_start", order_err_o, 0);
        for (int n = 0; n < 3000; n++) begin
            if (rst_at >= 0 && got.size() >= rst_at) begin
                finished = 1'b1;
                break;
            end
            if (done_cnt > 0 && !busy_o) begin
                finished = 1'b1;
                break;
            end
            start_i = (poke_at >= 0) && !poked && (got.size() == poke_at);
            if (start_i) poked = 1'b1;
            step();
            start_i = 1'b0;
        end
        check_eq("sweep_no_timeout", finished, 1);
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        check_eq({tag, "_len"}, got.size(), N);
        for (int i = 0; i < got.size() && i < N; i++) begin
            if (got[i] !== mem[i]) mism++;
        end
        check_eq({tag, "_data_mismatches"}, mism, 0);
        check_eq({tag, "_last_count"}, got_last_cnt, 1);
        check_eq({tag, "_last_pos"}, last_pos, N - 1);
        check_eq({tag, "_done_count"}, done_cnt, 1);
        check_eq({tag, "_outstanding_le2"}, (max_outst <= 2), 1);
    endtask

    task automatic check_timing(input string tag, input int k);
        check_eq({tag, "_first_valid"}, first_valid_cyc, k + 2);
        check_eq({tag, "_done_cycle"}, done_cyc, k + N + 2);
    endtask

    initial begin
        int k;
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        mem_rdata_i = '0;
        for (int i = 0; i < N; i++) mem[i] = DW'(i);

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_mem_rd", mem_rd_o, 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        check_eq("rst_out_valid", out_valid_o, 0);
        check_eq("rst_out_data", out_data_o, 0);
        check_eq("rst_out_last", out_last_o, 0);
        check_eq("rst_order_err", order_err_o, 0);
        rst = 1'b0;
        step();

        // Ascending contents, consumer always ready.
        run_sweep(1'b0, -1, -1, k);
        check_stream("asc");
        check_timing("asc", k);
        check_eq("asc_order_err", order_err_o, 0);
        check_eq("asc_busy_after", busy_o, 0);

        // Descending contents: error raised one cycle after the second pop, then sticky.
        for (int i = 0; i < N; i++) mem[i] = DW'(N - 1 - i);
        run_sweep(1'b0, -1, -1, k);
        check_stream("desc");
        check_eq("desc_err_cycle", err_cyc, pop1_cyc + 1);
        check_eq("desc_err_sticky", order_err_o, 1);
        repeat (3) step();
        check_eq("desc_err_idle_hold", order_err_o, 1);

        // Random contents with random backpressure.
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(0, 65535));
        run_sweep(1'b1, -1, -1, k);
        check_stream("rand");

        // All equal words: legal, and two back-to-back sweeps.
        for (int i = 0; i < N; i++) mem[i] = 16'h8000;
        run_sweep(1'b0, -1, -1, k);
        check_stream("eq1");
        check_eq("eq1_order_err", order_err_o, 0);
        run_sweep(1'b0, -1, -1, k);
        check_stream("eq2");
        check_timing("eq2", k);
        check_eq("eq2_order_err", order_err_o, 0);

        // start pulsed mid-sweep is ignored.
        for (int i = 0; i < N; i++) mem[i] = DW'(i);
        run_sweep(1'b0, 100, -1, k);
        check_stream("poke");
        check_timing("poke", k);

        // Asynchronous reset at word 50, then a clean restart.
        run_sweep(1'b0, -1, 50, k);
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_out_valid", out_valid_o, 0);
        check_eq("midrst_mem_rd", mem_rd_o, 0);
        check_eq("midrst_done", done_o, 0);
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        check_eq("midrst_no_done", done_cnt, 0);
        run_sweep(1'b0, -1, -1, k);
        check_stream("restart");
        check_timing("restart", k);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
